// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet field positions and packet typedef, common to
// the input handler, switch and output handler.
package noc_pkg;

  localparam int DATA_W  = 64;

  localparam int VC_BIT  = 63;
  localparam int DIR_BIT = 62;
  localparam int HOP_HI  = 55;
  localparam int HOP_LO  = 48;
  localparam int SRC_HI  = 47;
  localparam int SRC_LO  = 32;

  typedef struct packed {
    logic        vc;
    logic        dir;
    logic [5:0]  rsvd;
    logic [7:0]  hop;
    logic [15:0] src;
    logic [31:0] payload;
  } packet_t;

endpackage

// File: rtl/vc_slot.sv
// One virtual-channel buffer entry: packet register, full flag and a
// saturating counter of cycles spent full without being sent.
module vc_slot #(
  parameter int DATA_W      = 64,
  parameter int CNT_W       = 8,
  parameter int STALL_LIMIT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              clear,
  output logic [DATA_W-1:0] data,
  output logic              full,
  output logic              at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

  logic [DATA_W-1:0] data_q, data_d;
  logic              full_q, full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    data_d = data_q;
    full_d = full_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      full_d = 1'b1;
    end
    if (clear) begin
      full_d = 1'b0;
    end
    if (!full_q || clear) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: the data register is reset too, so pkt_out reads zero rather than stale bits after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
      data_q <= '0;
      full_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data     = data_q;
  assign full     = full_q;
  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/output_handler.sv
// Transmit end of a router link: two-entry even/odd VC buffer with hop
// decrement and stall detection. Optional OUTPUT_HANDLER_STATS_EN adds a sent-packet counter.
module output_handler
  import noc_pkg::*;
#(
  parameter int DATA_W      = noc_pkg::DATA_W,
  parameter int STALL_LIMIT = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic              wr_en,
  output logic              wr_rdy,
  input  logic [DATA_W-1:0] wr_data,
  output logic              so,
  input  logic              ro,
  output logic [DATA_W-1:0] pkt_out,
`ifdef OUTPUT_HANDLER_STATS_EN
  input  logic              stats_clr,
  output logic [15:0]       pkt_cnt,
`endif
  output logic              stall
);

  logic [DATA_W-1:0] slot_data [2];
  logic [1:0]        full;
  logic [1:0]        at_limit;
  logic [1:0]        load;
  logic [1:0]        clear;
  logic [DATA_W-1:0] load_data;
  logic              wr_fire;
  logic              send_fire;

  assign wr_rdy    = ~full[polarity];
  assign so        = full[~polarity];
  assign pkt_out   = slot_data[~polarity];
  assign stall     = |at_limit;
  assign wr_fire   = wr_en & wr_rdy;
  assign send_fire = so & ro;

  // Write goes to the current-phase slot, send drains the opposite one.
  always_comb begin
    load_data                 = wr_data;
    load_data[HOP_HI:HOP_LO]  = wr_data[HOP_HI:HOP_LO] >> 1;
    load                      = 2'b00;
    clear                     = 2'b00;
    load[polarity]            = wr_fire;
    clear[~polarity]          = send_fire;
  end

  for (genvar i = 0; i < 2; i++) begin : g_slot
    vc_slot #(
      .DATA_W      (DATA_W),
      .CNT_W       (CNT_W),
      .STALL_LIMIT (STALL_LIMIT)
    ) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .load_data (load_data),
      .clear     (clear[i]),
      .data      (slot_data[i]),
      .full      (full[i]),
      .at_limit  (at_limit[i])
    );
  end

`ifdef OUTPUT_HANDLER_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (stats_clr) begin
      pkt_cnt_d = '0;
    end else if (send_fire) begin
      pkt_cnt_d = pkt_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_output_handler.sv
// Directed table-driven bench for output_handler (STALL_LIMIT=4), with
// hand-written reset and, under OUTPUT_HANDLER_STATS_EN, counter sequences.
module tb_output_handler;

  logic        clk;
  logic        reset;
  logic        polarity;
  logic        wr_en;
  logic        wr_rdy;
  logic [63:0] wr_data;
  logic        so;
  logic        ro;
  logic [63:0] pkt_out;
  logic        stall;
`ifdef OUTPUT_HANDLER_STATS_EN
  logic        stats_clr;
  logic [15:0] pkt_cnt;
`endif

  int errors = 0;
  int checks = 0;

  output_handler #(
    .DATA_W      (64),
    .STALL_LIMIT (4),
    .CNT_W       (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .wr_en     (wr_en),
    .wr_rdy    (wr_rdy),
    .wr_data   (wr_data),
    .so        (so),
    .ro        (ro),
    .pkt_out   (pkt_out),
`ifdef OUTPUT_HANDLER_STATS_EN
    .stats_clr (stats_clr),
    .pkt_cnt   (pkt_cnt),
`endif
    .stall     (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pol;
    logic        we;
    logic [63:0] wd;
    logic        rdy;
    logic        e_wr_rdy;
    logic        e_so;
    logic [63:0] e_pkt;
    logic        e_stall;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pol, input logic we, input logic [63:0] wd, input logic rdy,
                     input logic e_wr_rdy, input logic e_so, input logic [63:0] e_pkt,
                     input logic e_stall);
    vec_t v;
    v.pol = pol; v.we = we; v.wd = wd; v.rdy = rdy;
    v.e_wr_rdy = e_wr_rdy; v.e_so = e_so; v.e_pkt = e_pkt; v.e_stall = e_stall;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic pol, input logic we,
                       input logic [63:0] wd, input logic rdy);
    reset    = r;
    polarity = pol;
    wr_en    = we;
    wr_data  = wd;
    ro       = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic e_rdy, input logic e_so,
                            input logic [63:0] e_pkt, input logic e_stall);
    check({tag, " wr_rdy"}, 64'(wr_rdy), 64'(e_rdy));
    check({tag, " so"},     64'(so),     64'(e_so));
    check({tag, " pkt_out"}, pkt_out,    e_pkt);
    check({tag, " stall"},  64'(stall),  64'(e_stall));
  endtask

  // Raw packets and their hop-shifted images (hop is bits [55:48]).
  localparam logic [63:0] PA  = 64'h000F_0000_ABCD_1234;
  localparam logic [63:0] PA_ = 64'h0007_0000_ABCD_1234;
  localparam logic [63:0] PB  = 64'hFFFF_0000_1111_2222;
  localparam logic [63:0] PB_ = 64'hFF7F_0000_1111_2222;
  localparam logic [63:0] PC  = 64'h0001_0000_3333_4444;
  localparam logic [63:0] PC_ = 64'h0000_0000_3333_4444;
  localparam logic [63:0] PD  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] PE  = 64'h8002_0000_5555_6666;
  localparam logic [63:0] PE_ = 64'h8001_0000_5555_6666;
  localparam logic [63:0] PF  = 64'h0000_0F00_ABCD_1234;

  initial begin
    //  pol we  wdata ro  | wr_rdy so pkt_out stall   (outputs before the edge)
    add(0, 0, '0, 0,   1, 0, '0,  0);   // idle, both phases
    add(1, 0, '0, 0,   1, 0, '0,  0);
    add(0, 1, PA, 0,   1, 0, '0,  0);   // write A into slot0
    add(1, 0, '0, 0,   1, 1, PA_, 0);   // offered next cycle, hop 0F->07
    add(0, 0, '0, 1,   0, 0, '0,  0);   // slot0 full, slot1 empty
    add(1, 0, '0, 1,   1, 1, PA_, 0);   // re-offered two cycles later, sent
    add(0, 0, '0, 0,   1, 0, '0,  0);
    add(1, 0, '0, 0,   1, 0, PA_, 0);   // slot0 empty again, stale data visible
    add(0, 1, PB, 0,   1, 0, '0,  0);   // fill slot0, hop FF->7F
    add(1, 1, PC, 0,   1, 1, PB_, 0);   // fill slot1, hop 01->00
    add(0, 1, PD, 0,   0, 1, PC_, 0);   // write ignored
    add(1, 1, PD, 0,   0, 1, PB_, 0);   // write ignored
    add(0, 0, '0, 0,   0, 1, PC_, 0);
    add(1, 0, '0, 0,   0, 1, PB_, 1);   // slot0 waited 4 cycles
    add(0, 0, '0, 1,   0, 1, PC_, 1);   // send slot1; slot0 still stalled
    add(1, 1, PE, 1,   1, 1, PB_, 1);   // load slot1 + send slot0 together
    add(0, 0, '0, 0,   1, 1, PE_, 0);   // stall dropped after slot0 sent
    add(1, 0, '0, 0,   0, 0, PB_, 0);
    add(0, 0, '0, 1,   1, 1, PE_, 0);   // send E
    add(1, 0, '0, 0,   1, 0, PB_, 0);
    add(0, 1, PF, 0,   1, 0, PE_, 0);   // hop=00 stays 00
    add(1, 0, '0, 1,   1, 1, PF,  0);
    add(0, 0, '0, 0,   1, 0, PE_, 0);

`ifdef OUTPUT_HANDLER_STATS_EN
    stats_clr = 1'b0;
`endif
    drive(1, 0, 0, '0, 0);
    tick();
    tick();
    drive(0, 0, 0, '0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(0, vecs[i].pol, vecs[i].we, vecs[i].wd, vecs[i].rdy);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].e_wr_rdy, vecs[i].e_so,
                 vecs[i].e_pkt, vecs[i].e_stall);
      tick();
    end

    // Reset with both slots full and a write pending drops everything.
    drive(0, 0, 1, PB, 0); tick();
    drive(0, 1, 1, PC, 0); tick();
    drive(0, 0, 0, '0, 0); #1;
    check_outs("prerst", 1'b0, 1'b1, PC_, 1'b0);
    drive(1, 0, 1, PD, 1); tick();
    drive(0, 1, 0, '0, 0); #1;
    check_outs("postrst_p1", 1'b1, 1'b0, 64'h0, 1'b0);
    tick();
    drive(0, 0, 0, '0, 0); #1;
    check_outs("postrst_p0", 1'b1, 1'b0, 64'h0, 1'b0);
    tick();

`ifdef OUTPUT_HANDLER_STATS_EN
    check("pkt_cnt after reset", 64'(pkt_cnt), 64'd0);
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 1, PA, 0); tick();
      drive(0, 1, 0, '0, 1); tick();
    end
    drive(0, 0, 0, '0, 0); #1;
    check("pkt_cnt 3 sends", 64'(pkt_cnt), 64'd3);
    drive(0, 0, 1, PA, 0); tick();
    drive(0, 1, 0, '0, 1);
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    drive(0, 0, 0, '0, 0); #1;
    check("pkt_cnt clr over send", 64'(pkt_cnt), 64'd0);
    check("slot freed by send", 64'(wr_rdy), 64'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
